uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the counterpart to the team's UART_tx. It recovers frames of start, 8 data bits LSB first, 1 parity bit and 1 stop bit from the serial line `rx`. Timing comes from an oversampling tick (16x baud) generated by the shared tick generator. It delivers each byte with a one-cycle valid strobe plus parity and framing error flags to downstream logic.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first)
OVERSAMPLE, 16, os_tick pulses per bit period; must be even and >= 8

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high; asynchronous to clk
os_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate
p_sel  input  1  parity select: 0 = even, 1 = odd; sampled when the start bit is confirmed
data_out  output  DATA_BITS  last received byte
data_valid  output  1  one-clk pulse when data_out and the error flags are updated
parity_err  output  1  received parity bit mismatches the computed parity
frame_err  output  1  stop bit sampled low
busy  output  1  high in every state except IDLE

Behaviour:
- rx passes through a 2-FF synchronizer, both flops reset to 1. All sampling uses the synchronized value rx_s.
- Reset (asynchronous, active-high) values: state=IDLE, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, tick counter=0, bit counter=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No data_valid is produced for it.
- Tick counter counts os_tick pulses only. Clock cycles without os_tick change no counter.
- FSM states:
  - IDLE: on rx_s==0 at an os_tick, clear the tick counter and go to START.
  - START: at tick OVERSAMPLE/2-1 (mid-bit), sample rx_s.
    - If 0: latch p_sel, clear counters, go to DATA.
    - If 1: false start (glitch); return to IDLE with no outputs changed.
  - DATA: every OVERSAMPLE ticks from the start mid-point, sample rx_s into the shift register MSB and shift right. After DATA_BITS samples, go to PARITY.
  - PARITY: sample after OVERSAMPLE ticks. Expected bit = XOR of data bits XOR latched p_sel. For even parity, the data ones plus the parity bit total an even count.
  - STOP: sample after OVERSAMPLE ticks. In the next clk cycle:
    - data_out <= shift register; data_valid=1 for exactly one cycle.
    - parity_err and frame_err are updated for this frame.
    - If stop==1, go to IDLE. If stop==0 (break/framing), go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 at an os_tick, then go to IDLE. This prevents a line held low from being decoded as repeated 0x00 frames.
- data_valid is asserted even when errors are present. The flags are valid in the same cycle as data_valid and hold until the next data_valid.
- data_out holds its value between frames.
- Latency from rx falling edge to data_valid: 2 clk (synchronizer) + (1.5 + DATA_BITS + 1) bit periods, ±1 os_tick.
- Back-to-back frames: a start edge is accepted in the first os_tick after returning to IDLE.

Optional Feature:
UART_RX_MAJORITY_EN:
- When defined, each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_s at ticks mid-1, mid and mid+1.
- When undefined, each bit is a single sample at mid.
- Frame timing and latency are identical in both builds.

Test Plan:
1. Reset asserted, rx=1 -> all outputs 0, busy=0. Release reset, idle 5 bit periods -> no data_valid.
2. p_sel=1, send 0xCC with parity bit 1 and stop 1 -> one data_valid pulse, data_out=0xCC, parity_err=0, frame_err=0. Then send 0xAD with parity bit 0 -> data_out=0xAD, no errors.
3. p_sel=0, send 0xAD with parity bit 0 (wrong; even parity requires 1) -> data_out=0xAD, parity_err=1, frame_err=0.
4. Send 0x55 with stop bit 0, then hold rx low 3 bit periods -> exactly one data_valid with frame_err=1 and busy held high. Release rx high -> busy=0. Next valid 0x3C frame received cleanly with both flags 0.
5. rx low pulse of 4 os_ticks in IDLE -> false start, busy returns to 0, no data_valid. Assert rst mid-data of a 0xFF frame -> busy=0 immediately, no data_valid for that frame.
6. With UART_RX_MAJORITY_EN defined: 1-os_tick glitch at mid of data bit 3 of 0xCC -> data_out=0xCC. Without the macro, the same glitch -> data_out=0xC4 and parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start + DATA_BITS (LSB first) + parity + stop, timed by an OVERSAMPLE x baud os_tick; no backpressure, one-cycle data_valid.
// Latency ~2 clk + (DATA_BITS + 2.5) bit periods; define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 os_tick,
  input  logic                 p_sel,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           hist_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 psel_q, psel_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 sample_now;
  logic                 bit_val;

  // hist_q holds rx_s from the two previous os_ticks; the decision tick is mid+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      hist_q    <= 2'b11;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      if (os_tick) hist_q <= {hist_q[0], rx_s_q};
    end
  end

  always_comb begin
`ifdef UART_RX_MAJORITY_EN
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    bit_val = hist_q[0];
`endif
  end

  always_comb begin
    sample_now = 1'b0;
    if (os_tick) begin
      if (state_q == S_START)
        sample_now = (tick_q == MID);
      else if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP)
        sample_now = (tick_q == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (os_tick && !rx_s_q) state_d = S_START;
      S_START:     if (sample_now) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:      if (sample_now && bit_q == LAST_BIT) state_d = S_PARITY;
      S_PARITY:    if (sample_now) state_d = S_STOP;
      S_STOP:      if (sample_now) state_d = bit_val ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (os_tick && rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    psel_d    = psel_q;
    par_bit_d = par_bit_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    case (state_q)
      S_IDLE: tick_d = '0;
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (sample_now) begin
          tick_d = '0;
          case (state_q)
            S_START: begin
              bit_d = '0;
              if (!bit_val) psel_d = p_sel;
            end
            S_DATA: begin
              shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
              bit_d   = bit_q + BW'(1);
            end
            S_PARITY: par_bit_d = bit_val;
            default: begin
              dout_d = shift_q;
              vld_d  = 1'b1;
              perr_d = par_bit_q != ((^shift_q) ^ psel_q);
              ferr_d = !bit_val;
            end
          endcase
        end else if (os_tick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      psel_q    <= 1'b0;
      par_bit_q <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      psel_q    <= psel_d;
      par_bit_q <= par_bit_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    data_out   = dout_q;
    data_valid = vld_q;
    parity_err = perr_q;
    frame_err  = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of fixed frames, hand-written corner sequences, then random frames against a parity/stop model.
module tb_uart_rx;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst, rx, os_tick, p_sel;
  logic [DB-1:0] data_out;
  logic          data_valid, parity_err, frame_err, busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .os_tick(os_tick), .p_sel(p_sel),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;
  logic [DB-1:0] mon_data = '0;
  logic mon_perr = 1'b0, mon_ferr = 1'b0;

  // Every high cycle of data_valid is counted, so a stretched strobe shows up as an extra count.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      vld_cnt  = vld_cnt + 1;
      mon_data = data_out;
      mon_perr = parity_err;
      mon_ferr = frame_err;
    end
  end

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns 1 time unit after the n-th rising edge that carries os_tick.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (os_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int glitch_idx);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rx = bits[b];
      if (b == glitch_idx) begin
        tick_wait(7);
        rx = ~bits[b];
        tick_wait(1);
        rx = bits[b];
        tick_wait(8);
      end else begin
        tick_wait(OS);
      end
    end
  endtask

  task automatic check_frame(input string nm, input int v0, input logic [7:0] ed,
                             input logic ep, input logic ef);
    chk({nm, ".vld_count"}, vld_cnt - v0, 1);
    chk({nm, ".data"}, mon_data, ed);
    chk({nm, ".parity_err"}, mon_perr, ep);
    chk({nm, ".frame_err"}, mon_ferr, ef);
    chk({nm, ".data_hold"}, data_out, ed);
  endtask

  function automatic logic good_parity(input logic [7:0] d, input logic ps);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'((ones + ps) % 2);
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       ps;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vt[6];

  initial begin
    int v0;
    int busy_low;
    logic [7:0] rd;
    logic rps, rpb, rsb, gp;

    vt[0] = '{8'hCC, 1'b1, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0};
    vt[1] = '{8'hAD, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b0};
    vt[2] = '{8'hAD, 1'b0, 1'b1, 1'b0, 8'hAD, 1'b1, 1'b0};
    vt[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; rx = 1'b1; p_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.data_out", data_out, 0);
    chk("reset.data_valid", data_valid, 0);
    chk("reset.parity_err", parity_err, 0);
    chk("reset.frame_err", frame_err, 0);
    chk("reset.busy", busy, 0);
    rst = 1'b0;
    tick_wait(5 * OS);
    chk("idle.no_valid", vld_cnt, 0);
    chk("idle.busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      p_sel = vt[i].ps;
      v0 = vld_cnt;
      send_frame(vt[i].d, vt[i].pb, vt[i].sb, -1);
      rx = 1'b1;
      tick_wait(4);
      check_frame($sformatf("vec%0d", i), v0, vt[i].ed, vt[i].ep, vt[i].ef);
    end

    // Stop bit low followed by a long break: one strobe, busy held until the line rises.
    p_sel = 1'b0;
    v0 = vld_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    busy_low = 0;
    for (int i = 0; i < 3 * OS; i++) begin
      tick_wait(1);
      if (busy !== 1'b1) busy_low++;
    end
    chk("break.busy_hold", busy_low, 0);
    check_frame("break", v0, 8'h55, 1'b0, 1'b1);
    rx = 1'b1;
    tick_wait(2);
    chk("break.busy_release", busy, 0);
    v0 = vld_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick_wait(4);
    check_frame("after_break", v0, 8'h3C, 1'b0, 1'b0);

    // Short low pulse in idle is rejected at the start-bit centre.
    v0 = vld_cnt;
    rx = 1'b0;
    tick_wait(4);
    chk("glitch.busy_during", busy, 1);
    rx = 1'b1;
    tick_wait(10);
    chk("glitch.busy_after", busy, 0);
    chk("glitch.no_valid", vld_cnt - v0, 0);
    chk("glitch.data_hold", data_out, 8'h3C);

    // Reset in the middle of a data bit aborts the frame.
    v0 = vld_cnt;
    rx = 1'b0;
    tick_wait(OS);
    rx = 1'b1;
    tick_wait(40);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.data_valid", data_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick_wait(200);
    chk("midrst.no_valid", vld_cnt - v0, 0);
    chk("midrst.data_out", data_out, 0);

    // One-tick glitch at the centre of data bit 3 of 0xCC.
    p_sel = 1'b1;
    v0 = vld_cnt;
    send_frame(8'hCC, 1'b1, 1'b1, 4);
    rx = 1'b1;
    tick_wait(4);
`ifdef UART_RX_MAJORITY_EN
    check_frame("midglitch", v0, 8'hCC, 1'b0, 1'b0);
`else
    check_frame("midglitch", v0, 8'hC4, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      rd  = 8'($urandom);
      rps = 1'($urandom_range(0, 1));
      gp  = good_parity(rd, rps);
      rpb = ($urandom_range(0, 3) == 0) ? ~gp : gp;
      rsb = ($urandom_range(0, 4) != 0);
      p_sel = rps;
      v0 = vld_cnt;
      send_frame(rd, rpb, rsb, -1);
      rx = 1'b1;
      tick_wait($urandom_range(1, 6));
      check_frame($sformatf("rnd%0d", i), v0, rd, rpb != gp, !rsb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
